// File: rtl/reversi_pkg.sv
// Shared types and helpers for the reversi board-cursor logic.
package reversi_pkg;

  localparam int DEF_BOARD_W = 8;
  localparam int DEF_BOARD_H = 8;

  typedef enum logic [2:0] {DIR_NONE, DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, BLOCKED} cursor_state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One axis per event: Right > Left > Up > Down.
  function automatic dir_t prioDecode(input logic right, input logic left,
                                      input logic up, input logic down);
    if (right)     return DIR_RIGHT;
    else if (left) return DIR_LEFT;
    else if (up)   return DIR_UP;
    else if (down) return DIR_DOWN;
    else           return DIR_NONE;
  endfunction

endpackage

// File: rtl/cursor_repeat_timer.sv
// Press-edge / typematic repeat sequencer; raises stepReq in the cycle a step is due.
//   state   | meaning
//   IDLE    | no direction held
//   DELAY   | first step taken, waiting REPEAT_DELAY cycles
//   REPEAT  | auto-repeating every REPEAT_RATE cycles
//   BLOCKED | locked or just loaded; waits for buttons released and lock dropped
module cursor_repeat_timer
  import reversi_pkg::*;
#(
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] dirCode,
  input  logic       lockEn,
  input  logic       loadEn,
  output logic       stepReq
);

  localparam int CNT_MAX = maxInt(REPEAT_DELAY, REPEAT_RATE);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  dir_t              dir;
  dir_t              lastDir;
  cursor_state_t     state;
  logic [CNT_W-1:0]  counter;

  assign dir = dir_t'(dirCode);

  always_comb begin
    stepReq = 1'b0;
    if (!loadEn && !lockEn && dir != DIR_NONE) begin
      case (state)
        IDLE:    stepReq = 1'b1;
        DELAY:   stepReq = (dir != lastDir) || (counter == DELAY_LAST);
        REPEAT:  stepReq = (dir != lastDir) || (counter == RATE_LAST);
        default: stepReq = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      lastDir <= DIR_NONE;
    end else if (loadEn) begin
      state   <= (dir != DIR_NONE) ? BLOCKED : IDLE;
      counter <= '0;
    end else if (lockEn) begin
      state   <= BLOCKED;
      counter <= '0;
    end else if (state == BLOCKED) begin
      if (dir == DIR_NONE) state <= IDLE;
    end else if (dir == DIR_NONE) begin
      state   <= IDLE;
      counter <= '0;
    end else if (stepReq) begin
      // Same direction reaching terminal count keeps repeating; anything else is a fresh press.
      state   <= (state != IDLE && dir == lastDir) ? REPEAT : DELAY;
      counter <= '0;
      lastDir <= dir;
    end else begin
      counter <= counter + CNT_ONE;
    end
  end

endmodule

// File: rtl/cursor_move_ctrl.sv
// Board-cursor controller: coordinate registers, edge clamp/wrap and direct load,
// driven by the repeat timer's step requests.
module cursor_move_ctrl
  import reversi_pkg::*;
#(
  parameter int BOARD_W      = DEF_BOARD_W,
  parameter int BOARD_H      = DEF_BOARD_H,
  parameter int WRAP_EN      = 0,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int INIT_X       = 3,
  parameter int INIT_Y       = 3,
  localparam int CW          = $clog2(maxInt(BOARD_W, BOARD_H))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          moveRightEn,
  input  logic          moveLeftEn,
  input  logic          moveUpEn,
  input  logic          moveDownEn,
  input  logic          lockEn,
  input  logic          loadEn,
  input  logic [CW-1:0] loadX,
  input  logic [CW-1:0] loadY,
  output logic [CW-1:0] xCoord,
  output logic [CW-1:0] yCoord,
  output logic          moved
);

  localparam logic [CW-1:0] X_LAST = CW'(BOARD_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(BOARD_H - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  dir_t          dir;
  logic          stepReq;
  logic          stepValid;
  logic [CW-1:0] stepX;
  logic [CW-1:0] stepY;

  assign dir = prioDecode(moveRightEn, moveLeftEn, moveUpEn, moveDownEn);

  cursor_repeat_timer #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) uTimer (
    .clk    (clk),
    .reset  (reset),
    .dirCode(dir),
    .lockEn (lockEn),
    .loadEn (loadEn),
    .stepReq(stepReq)
  );

  // stepValid drops when clamping suppresses a step at the board edge.
  always_comb begin
    stepX     = xCoord;
    stepY     = yCoord;
    stepValid = 1'b0;
    case (dir)
      DIR_RIGHT:
        if (xCoord != X_LAST) begin
          stepX = xCoord + ONE;  stepValid = 1'b1;
        end else if (WRAP_EN != 0) begin
          stepX = '0;            stepValid = 1'b1;
        end
      DIR_LEFT:
        if (xCoord != '0) begin
          stepX = xCoord - ONE;  stepValid = 1'b1;
        end else if (WRAP_EN != 0) begin
          stepX = X_LAST;        stepValid = 1'b1;
        end
      DIR_UP:
        if (yCoord != '0) begin
          stepY = yCoord - ONE;  stepValid = 1'b1;
        end else if (WRAP_EN != 0) begin
          stepY = Y_LAST;        stepValid = 1'b1;
        end
      DIR_DOWN:
        if (yCoord != Y_LAST) begin
          stepY = yCoord + ONE;  stepValid = 1'b1;
        end else if (WRAP_EN != 0) begin
          stepY = '0;            stepValid = 1'b1;
        end
      default: stepValid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xCoord <= CW'(INIT_X);
      yCoord <= CW'(INIT_Y);
      moved  <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (loadEn) begin
        xCoord <= (loadX > X_LAST) ? X_LAST : loadX;
        yCoord <= (loadY > Y_LAST) ? Y_LAST : loadY;
        moved  <= 1'b1;
      end else if (stepReq && stepValid) begin
        xCoord <= stepX;
        yCoord <= stepY;
        moved  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Vector/scoreboard bench for cursor_move_ctrl: clamp 8x8, wrap 8x8 and clamp 6x6 instances.
module tb_cursor_move_ctrl;
  import reversi_pkg::*;

  localparam int CW = 3;
  localparam logic [3:0] BN = 4'b0000, BR = 4'b1000, BL = 4'b0100, BU = 4'b0010, BD = 4'b0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic moveRightEn = 0, moveLeftEn = 0, moveUpEn = 0, moveDownEn = 0;
  logic lockEn = 0, loadEn = 0;
  logic [CW-1:0] loadX = '0, loadY = '0;
  logic [CW-1:0] xA, yA, xB, yB, xC, yC;
  logic movedA, movedB, movedC;

  cursor_move_ctrl #(.BOARD_W(8), .BOARD_H(8), .WRAP_EN(0), .REPEAT_DELAY(4), .REPEAT_RATE(2),
                     .INIT_X(3), .INIT_Y(3)) dutA (
    .clk(clk), .reset(reset), .moveRightEn(moveRightEn), .moveLeftEn(moveLeftEn),
    .moveUpEn(moveUpEn), .moveDownEn(moveDownEn), .lockEn(lockEn), .loadEn(loadEn),
    .loadX(loadX), .loadY(loadY), .xCoord(xA), .yCoord(yA), .moved(movedA));

  cursor_move_ctrl #(.BOARD_W(8), .BOARD_H(8), .WRAP_EN(1), .REPEAT_DELAY(4), .REPEAT_RATE(2),
                     .INIT_X(3), .INIT_Y(3)) dutB (
    .clk(clk), .reset(reset), .moveRightEn(moveRightEn), .moveLeftEn(moveLeftEn),
    .moveUpEn(moveUpEn), .moveDownEn(moveDownEn), .lockEn(lockEn), .loadEn(loadEn),
    .loadX(loadX), .loadY(loadY), .xCoord(xB), .yCoord(yB), .moved(movedB));

  cursor_move_ctrl #(.BOARD_W(6), .BOARD_H(6), .WRAP_EN(0), .REPEAT_DELAY(4), .REPEAT_RATE(2),
                     .INIT_X(3), .INIT_Y(3)) dutC (
    .clk(clk), .reset(reset), .moveRightEn(moveRightEn), .moveLeftEn(moveLeftEn),
    .moveUpEn(moveUpEn), .moveDownEn(moveDownEn), .lockEn(lockEn), .loadEn(loadEn),
    .loadX(loadX), .loadY(loadY), .xCoord(xC), .yCoord(yC), .moved(movedC));

  typedef struct {
    string         name;
    int            dut;
    logic          rst;
    logic [3:0]    btn;
    logic          lock;
    logic          load;
    logic [CW-1:0] lx, ly;
    logic [CW-1:0] ex, ey;
    logic          em;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int nVec = 0;
  int nMis = 0;

  function automatic vec_t mkv(string name, int dut, logic rst, logic [3:0] btn, logic lock,
                               logic load, int lx, int ly, int ex, int ey, logic em);
    vec_t v;
    v.name = name; v.dut = dut; v.rst = rst; v.btn = btn; v.lock = lock; v.load = load;
    v.lx = CW'(lx); v.ly = CW'(ly); v.ex = CW'(ex); v.ey = CW'(ey); v.em = em;
    return v;
  endfunction

  // Inputs are held for one cycle; the result is sampled 1 ns after the following edge.
  task automatic apply(input vec_t v);
    vec_t e;
    logic [CW-1:0] ax, ay;
    logic am;
    reset = v.rst;
    {moveRightEn, moveLeftEn, moveUpEn, moveDownEn} = v.btn;
    lockEn = v.lock; loadEn = v.load; loadX = v.lx; loadY = v.ly;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    case (e.dut)
      0:       begin ax = xA; ay = yA; am = movedA; end
      1:       begin ax = xB; ay = yB; am = movedB; end
      default: begin ax = xC; ay = yC; am = movedC; end
    endcase
    nVec++;
    if (ax !== e.ex || ay !== e.ey || am !== e.em) begin
      nMis++;
      $display("FAIL %s (dut %0d): got x=%0d y=%0d moved=%b, want x=%0d y=%0d moved=%b",
               e.name, e.dut, ax, ay, am, e.ex, e.ey, e.em);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clamp instance: reset, repeat timing, clamp, priority, lock, load, mid-run reset.
    tbl.push_back(mkv("rst_hold",      0, 1, BR|BD, 0, 0, 0, 0, 3, 3, 0));
    tbl.push_back(mkv("rst_hold2",     0, 1, BR|BD, 0, 0, 0, 0, 3, 3, 0));
    tbl.push_back(mkv("rst_rel_right", 0, 0, BR,    0, 0, 0, 0, 4, 3, 1));
    tbl.push_back(mkv("right_held",    0, 0, BR,    0, 0, 0, 0, 4, 3, 0));
    tbl.push_back(mkv("release",       0, 0, BN,    0, 0, 0, 0, 4, 3, 0));
    tbl.push_back(mkv("load_origin",   0, 0, BN,    0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mkv("rep_c0",        0, 0, BR,    0, 0, 0, 0, 1, 0, 1));
    for (int i = 1; i <= 3; i++)
      tbl.push_back(mkv("rep_delay",   0, 0, BR,    0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mkv("rep_c4",        0, 0, BR,    0, 0, 0, 0, 2, 0, 1));
    tbl.push_back(mkv("rep_c5",        0, 0, BR,    0, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mkv("rep_c6",        0, 0, BR,    0, 0, 0, 0, 3, 0, 1));
    tbl.push_back(mkv("rep_c7",        0, 0, BR,    0, 0, 0, 0, 3, 0, 0));
    tbl.push_back(mkv("rep_c8",        0, 0, BR,    0, 0, 0, 0, 4, 0, 1));
    tbl.push_back(mkv("rep_release",   0, 0, BN,    0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mkv("clamp_up",      0, 0, BU,    0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mkv("release",       0, 0, BN,    0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mkv("load_edge",     0, 0, BN,    0, 1, 7, 0, 7, 0, 1));
    tbl.push_back(mkv("clamp_right",   0, 0, BR,    0, 0, 0, 0, 7, 0, 0));
    tbl.push_back(mkv("release",       0, 0, BN,    0, 0, 0, 0, 7, 0, 0));
    tbl.push_back(mkv("load_mid",      0, 0, BN,    0, 1, 3, 3, 3, 3, 1));
    tbl.push_back(mkv("prio_ru",       0, 0, BR|BU, 0, 0, 0, 0, 4, 3, 1));
    tbl.push_back(mkv("prio_ru_hold",  0, 0, BR|BU, 0, 0, 0, 0, 4, 3, 0));
    tbl.push_back(mkv("drop_right",    0, 0, BU,    0, 0, 0, 0, 4, 2, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv("up_delay",    0, 0, BU,    0, 0, 0, 0, 4, 2, 0));
    tbl.push_back(mkv("up_first_rep",  0, 0, BU,    0, 0, 0, 0, 4, 1, 1));
    tbl.push_back(mkv("release",       0, 0, BN,    0, 0, 0, 0, 4, 1, 0));
    tbl.push_back(mkv("prio_ld",       0, 0, BL|BD, 0, 0, 0, 0, 3, 1, 1));
    tbl.push_back(mkv("release",       0, 0, BN,    0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mkv("down_press",    0, 0, BD,    0, 0, 0, 0, 3, 2, 1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mkv("lock_held",   0, 0, BD,    1, 0, 0, 0, 3, 2, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv("unlock_held", 0, 0, BD,    0, 0, 0, 0, 3, 2, 0));
    tbl.push_back(mkv("unlock_rel",    0, 0, BN,    0, 0, 0, 0, 3, 2, 0));
    tbl.push_back(mkv("repress",       0, 0, BD,    0, 0, 0, 0, 3, 3, 1));
    tbl.push_back(mkv("release",       0, 0, BN,    0, 0, 0, 0, 3, 3, 0));
    tbl.push_back(mkv("load_left",     0, 0, BL,    0, 1, 7, 2, 7, 2, 1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv("load_blocked",0, 0, BL,    0, 0, 0, 0, 7, 2, 0));
    tbl.push_back(mkv("release",       0, 0, BN,    0, 0, 0, 0, 7, 2, 0));
    tbl.push_back(mkv("left_press",    0, 0, BL,    0, 0, 0, 0, 6, 2, 1));
    tbl.push_back(mkv("left_held",     0, 0, BL,    0, 0, 0, 0, 6, 2, 0));
    tbl.push_back(mkv("rst_mid",       0, 1, BL,    0, 0, 0, 0, 3, 3, 0));
    tbl.push_back(mkv("after_rst",     0, 0, BN,    0, 0, 0, 0, 3, 3, 0));
    tbl.push_back(mkv("load_locked",   0, 0, BN,    1, 1, 1, 6, 1, 6, 1));
    tbl.push_back(mkv("press_post_ld", 0, 0, BR,    0, 0, 0, 0, 2, 6, 1));
    tbl.push_back(mkv("release",       0, 0, BN,    0, 0, 0, 0, 2, 6, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // Wrap instance: every edge crossing lands on the opposite edge.
    apply(mkv("w_rst",        1, 1, BN, 0, 0, 0, 0, 3, 3, 0));
    apply(mkv("w_load",       1, 0, BN, 0, 1, 7, 0, 7, 0, 1));
    apply(mkv("w_right_wrap", 1, 0, BR, 0, 0, 0, 0, 0, 0, 1));
    apply(mkv("w_release",    1, 0, BN, 0, 0, 0, 0, 0, 0, 0));
    apply(mkv("w_up_wrap",    1, 0, BU, 0, 0, 0, 0, 0, 7, 1));
    apply(mkv("w_release",    1, 0, BN, 0, 0, 0, 0, 0, 7, 0));
    apply(mkv("w_left_wrap",  1, 0, BL, 0, 0, 0, 0, 7, 7, 1));
    apply(mkv("w_release",    1, 0, BN, 0, 0, 0, 0, 7, 7, 0));
    apply(mkv("w_down_wrap",  1, 0, BD, 0, 0, 0, 0, 7, 0, 1));
    apply(mkv("w_release",    1, 0, BN, 0, 0, 0, 0, 7, 0, 0));

    // 6x6 instance: load saturates to BOARD-1 and clamps against 5, not 7.
    apply(mkv("s_rst",        2, 1, BN, 0, 0, 0, 0, 3, 3, 0));
    apply(mkv("s_load_left",  2, 0, BL, 0, 1, 7, 2, 5, 2, 1));
    apply(mkv("s_blocked",    2, 0, BL, 0, 0, 0, 0, 5, 2, 0));
    apply(mkv("s_blocked2",   2, 0, BL, 0, 0, 0, 0, 5, 2, 0));
    apply(mkv("s_release",    2, 0, BN, 0, 0, 0, 0, 5, 2, 0));
    apply(mkv("s_left",       2, 0, BL, 0, 0, 0, 0, 4, 2, 1));
    apply(mkv("s_release",    2, 0, BN, 0, 0, 0, 0, 4, 2, 0));
    apply(mkv("s_load_sat",   2, 0, BN, 0, 1, 7, 7, 5, 5, 1));
    apply(mkv("s_clamp_r",    2, 0, BR, 0, 0, 0, 0, 5, 5, 0));
    apply(mkv("s_release",    2, 0, BN, 0, 0, 0, 0, 5, 5, 0));
    apply(mkv("s_clamp_d",    2, 0, BD, 0, 0, 0, 0, 5, 5, 0));
    apply(mkv("s_release",    2, 0, BN, 0, 0, 0, 0, 5, 5, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
